booth_ctrl: RTL and testbench
=============================

BOOTH_CTRL -- requirements
Module: booth_ctrl

Interface
REQ-001 The block SHALL have parameter n, default 3, giving the multiplier/multiplicand width and the number of Booth iterations.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to run one multiplication; sampled only in IDLE.
REQ-005 The block SHALL have port cmp, input, 1 bit: from datapath; 1 means the current bit pair {Q[0],q} needs an add or subtract.
REQ-006 The block SHALL have port incr, input, 1 bit: from datapath; 0 means the datapath has completed n shifts and the product is valid.
REQ-007 The block SHALL have port clr, output, 1 bit: datapath register clear.
REQ-008 The block SHALL have port ld, output, 1 bit: datapath operand load.
REQ-009 The block SHALL have port add_sub, output, 1 bit: datapath add/subtract step.
REQ-010 The block SHALL have port shft, output, 1 bit: datapath arithmetic right shift.
REQ-011 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse when the product is valid.
REQ-013 The block SHALL have port err, output, 1 bit: sticky flag for an incr/count mismatch.

Function
REQ-014 All outputs SHALL be registered Moore outputs decoded from the state; no output SHALL depend combinationally on an input.
REQ-015 At most one of clr, ld, add_sub and shft SHALL be high in any cycle.
REQ-016 States SHALL be IDLE, CLEAR, LOAD, CHECK, ARITH, SHIFT and FIN.
REQ-017 IDLE SHALL drive all outputs 0 except err, and SHALL go to CLEAR when start=1; otherwise it stays in IDLE.
REQ-018 CLEAR SHALL drive clr=1 for exactly 1 cycle, clear err and the internal count to 0, then go to LOAD.
REQ-019 LOAD SHALL drive ld=1 for exactly 1 cycle, then go to CHECK.
REQ-020 CHECK SHALL drive no control strobe; transitions are evaluated in this priority order:
- incr=0 while count<n: set err=1, go to FIN (premature completion).
- cmp=1: go to ARITH.
- otherwise: go to SHIFT.
REQ-021 ARITH SHALL drive add_sub=1 for 1 cycle, then go to SHIFT.
REQ-022 SHIFT SHALL drive shft=1 for 1 cycle and increment the count.
- If the count after increment equals n, go to FIN.
- Otherwise go to CHECK.
REQ-023 FIN SHALL drive done=1 for exactly 1 cycle and set err=1 if incr=1 in that cycle, then go to IDLE.
REQ-024 The count register SHALL be clog2(n+1) bits wide and SHALL never exceed n.
REQ-025 Latency: with start sampled at edge E0 and k = number of iterations with cmp=1, done SHALL be high in cycle 2n+k+3 after E0, with CLEAR being cycle 1.
REQ-026 A start asserted while busy=1 SHALL be ignored and not queued.
REQ-027 start held high through FIN SHALL begin a new run in the cycle after the return to IDLE.
REQ-028 err SHALL hold its value from FIN through IDLE until the next CLEAR.

Reset
REQ-029 rst=1 SHALL immediately, without waiting for clk, force state IDLE, count 0 and clr=ld=add_sub=shft=busy=done=err=0.
REQ-030 A reset mid-operation SHALL abandon the run with no done pulse.
- The first post-reset start SHALL run a complete CLEAR-LOAD sequence.

Verification
REQ-031 The bench SHALL cover: n=3, multiplicand 2, multiplier 3 (k=2), with the bth_mlt datapath attached -> strobe sequence clr, ld, add_sub, shft, shft, add_sub, shft; done in cycle 11; P=6; err=0.
REQ-032 The bench SHALL cover: n=3, multiplier 0 (k=0) -> no add_sub; done in cycle 9; P=0.
REQ-033 The bench SHALL cover: n=3, multiplicand 3, multiplier 3'b101 (-3) (k=3) -> done in cycle 12; P=6'b110111 (-9).
REQ-034 The bench SHALL cover: rst pulsed during the second SHIFT -> all outputs 0 before the next clk edge; no done; the next run completes correctly.
REQ-035 The bench SHALL cover: incr forced 0 in the first CHECK -> FIN next cycle, done=1, err=1; err stays 1 until the next CLEAR.
REQ-036 The bench SHALL cover: start toggled during a run, then held high -> no disturbance mid-run; back-to-back runs separated by exactly one IDLE cycle.

Source files
------------

// File: rtl/booth_ctrl_if.sv
// rtl/booth_ctrl_if.sv - Booth controller handshake and datapath strobe bundle
//
// Purpose: groups the request input, the datapath status inputs and the
// registered control/status outputs of booth_ctrl.
// Signals:
//   start   - request one multiplication (master -> controller)
//   cmp     - datapath bit pair {Q[0],q} needs add/subtract
//   incr    - datapath still shifting; 0 once n shifts are done
//   clr     - datapath register clear strobe
//   ld      - datapath operand load strobe
//   add_sub - datapath add/subtract strobe
//   shft    - datapath arithmetic right shift strobe
//   busy    - controller not idle
//   done    - one-cycle product-valid pulse
//   err     - sticky incr/count mismatch flag
// Modports: master drives start/cmp/incr; slave is the controller.
interface booth_ctrl_if;
    logic start;
    logic cmp;
    logic incr;
    logic clr;
    logic ld;
    logic add_sub;
    logic shft;
    logic busy;
    logic done;
    logic err;

    modport master (
        output start, cmp, incr,
        input  clr, ld, add_sub, shft, busy, done, err
    );

    modport slave (
        input  start, cmp, incr,
        output clr, ld, add_sub, shft, busy, done, err
    );
endinterface

// File: rtl/booth_ctrl.sv
// rtl/booth_ctrl.sv - Booth radix-2 multiplier sequencing controller
//
// Purpose: sequences a Booth datapath through clear, load and n
// check/(add-sub)/shift iterations, then pulses done. All outputs are
// flops decoded from the next state, so none depends combinationally on
// an input.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset
//   bus - booth_ctrl_if.slave: start/cmp/incr in; clr/ld/add_sub/shft/
//         busy/done/err out
// Parameter:
//   n   - operand width and number of Booth iterations
module booth_ctrl #(
    parameter int n = 3
) (
    input  logic          clk,
    input  logic          rst,
    booth_ctrl_if.slave   bus
);
    localparam int CW = $clog2(n + 1);
    localparam logic [CW-1:0] N_CNT = CW'(n);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LOAD  = 3'd2,
        CHECK = 3'd3,
        ARITH = 3'd4,
        SHIFT = 3'd5,
        FIN   = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;
    logic          clr_q, ld_q, add_sub_q, shft_q, busy_q, done_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // Cleared on entry so err already reads 0 during CLEAR.
                    state_d = CLEAR;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            CLEAR: state_d = LOAD;
            LOAD:  state_d = CHECK;
            CHECK: begin
                // Datapath claims completion before n shifts: abort with err.
                if (!bus.incr && (count_q < N_CNT)) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else if (bus.cmp) begin
                    state_d = ARITH;
                end else begin
                    state_d = SHIFT;
                end
            end
            ARITH: state_d = SHIFT;
            SHIFT: begin
                count_d = count_q + CW'(1);
                state_d = (count_d == N_CNT) ? FIN : CHECK;
            end
            FIN: begin
                // Datapath still wants to shift after n iterations.
                if (bus.incr) begin
                    err_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            err_q     <= 1'b0;
            clr_q     <= 1'b0;
            ld_q      <= 1'b0;
            add_sub_q <= 1'b0;
            shft_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            err_q     <= err_d;
            clr_q     <= (state_d == CLEAR);
            ld_q      <= (state_d == LOAD);
            add_sub_q <= (state_d == ARITH);
            shft_q    <= (state_d == SHIFT);
            busy_q    <= (state_d != IDLE);
            done_q    <= (state_d == FIN);
        end
    end

    assign bus.clr     = clr_q;
    assign bus.ld      = ld_q;
    assign bus.add_sub = add_sub_q;
    assign bus.shft    = shft_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_booth_ctrl.sv
// tb/tb_booth_ctrl.sv - self-checking bench for booth_ctrl with a Booth datapath
module tb_booth_ctrl;
    localparam int N = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    booth_ctrl_if bus();

    booth_ctrl #(.n(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // bth_mlt-style datapath: A accumulator, Q multiplier, q extra bit.
    logic [N-1:0] dp_a, dp_q, dp_m, mcnd_in, mplr_in;
    logic         dp_q1;
    int           dp_cnt;
    bit           force0 = 1'b0;
    bit           force1 = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_a <= '0; dp_q <= '0; dp_m <= '0; dp_q1 <= 1'b0; dp_cnt <= 0;
        end else if (bus.clr) begin
            dp_a <= '0; dp_q1 <= 1'b0; dp_cnt <= 0;
        end else if (bus.ld) begin
            dp_q <= mplr_in; dp_m <= mcnd_in;
        end else if (bus.add_sub) begin
            if (dp_q[0] && !dp_q1)      dp_a <= dp_a - dp_m;
            else if (!dp_q[0] && dp_q1) dp_a <= dp_a + dp_m;
        end else if (bus.shft) begin
            {dp_a, dp_q, dp_q1} <= {dp_a[N-1], dp_a, dp_q};
            dp_cnt <= dp_cnt + 1;
        end
    end

    assign bus.cmp  = dp_q[0] ^ dp_q1;
    assign bus.incr = force0 ? 1'b0 : (force1 ? 1'b1 : (dp_cnt < N));

    // Results of the most recent run.
    int             done_cyc;
    logic [2*N-1:0] prod;
    logic           err_done, err_c1, post_busy, post_done, post_err;
    int             multi, gaps;
    logic [31:0]    seq_code;

    // Reference model: Booth recoding of the multiplier.
    function automatic int ref_k(input logic [N-1:0] mp);
        int k = 0;
        logic prev = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (mp[i] != prev) k++;
            prev = mp[i];
        end
        return k;
    endfunction

    // Strobe codes in base 8: 1 clr, 2 ld, 3 add_sub, 4 shft.
    function automatic logic [31:0] ref_seq(input logic [N-1:0] mp);
        logic [31:0] s = 32'o12;
        logic prev = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (mp[i] != prev) s = s * 8 + 3;
            s = s * 8 + 4;
            prev = mp[i];
        end
        return s;
    endfunction

    function automatic logic [2*N-1:0] ref_prod(input logic [N-1:0] mc, input logic [N-1:0] mp);
        logic signed [2*N-1:0] a, b;
        a = $signed(mc);
        b = $signed(mp);
        return a * b;
    endfunction

    // mode 0: drop start after E0; 1: hold start high; 2: toggle, then hold high.
    task automatic do_run(input logic [N-1:0] mc, input logic [N-1:0] mp, input int mode);
        mcnd_in = mc; mplr_in = mp;
        done_cyc = -1; seq_code = '0; multi = 0; gaps = 0;
        prod = '0; err_done = 1'b0; err_c1 = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        if (mode == 0) bus.start = 1'b0;
        for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (mode == 2) bus.start = (c >= 2 * N) ? 1'b1 : 1'($urandom_range(0, 1));
            if (int'(bus.clr) + int'(bus.ld) + int'(bus.add_sub) + int'(bus.shft) > 1) multi++;
            if (!bus.busy) gaps++;
            if (c == 1) err_c1 = bus.err;
            if (bus.clr)     seq_code = seq_code * 8 + 1;
            if (bus.ld)      seq_code = seq_code * 8 + 2;
            if (bus.add_sub) seq_code = seq_code * 8 + 3;
            if (bus.shft)    seq_code = seq_code * 8 + 4;
            if (bus.done) begin
                done_cyc = c; prod = {dp_a, dp_q}; err_done = bus.err;
            end
        end
        @(negedge clk);
        post_busy = bus.busy; post_done = bus.done; post_err = bus.err;
    endtask

    task automatic test_reset;
        bus.start = 1'b0;
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.clr, bus.ld, bus.add_sub, bus.shft, bus.busy, bus.done, bus.err} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 0000000",
                {bus.clr, bus.ld, bus.add_sub, bus.shft, bus.busy, bus.done, bus.err});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed;
        logic [N-1:0]   mcs [3] = '{3'd2, 3'd5, 3'd3};
        logic [N-1:0]   mps [3] = '{3'd3, 3'd0, 3'b101};
        int             cyc [3] = '{11, 9, 12};
        logic [2*N-1:0] pp  [3] = '{6'd6, 6'd0, 6'b110111};
        logic [31:0]    sq  [3] = '{32'o1234434, 32'o12444, 32'o12343434};
        for (int t = 0; t < 3; t++) begin
            do_run(mcs[t], mps[t], 0);
            n_checks++;
            if (done_cyc !== cyc[t]) begin
                n_fail++; $display("FAIL dir%0d_done_cycle: got %0d expected %0d", t, done_cyc, cyc[t]);
            end
            n_checks++;
            if (prod !== pp[t]) begin
                n_fail++; $display("FAIL dir%0d_product: got %b expected %b", t, prod, pp[t]);
            end
            n_checks++;
            if (seq_code !== sq[t]) begin
                n_fail++; $display("FAIL dir%0d_strobes: got %o expected %o", t, seq_code, sq[t]);
            end
            n_checks++;
            if ({err_done, post_busy, post_done} !== 3'b000) begin
                n_fail++; $display("FAIL dir%0d_err_idle: got %b expected 000", t, {err_done, post_busy, post_done});
            end
            n_checks++;
            if (multi != 0 || gaps != 0) begin
                n_fail++; $display("FAIL dir%0d_onehot_busy: got multi=%0d gaps=%0d expected 0 0", t, multi, gaps);
            end
        end
    endtask

    task automatic test_random;
        logic [N-1:0] mc, mp;
        for (int t = 0; t < 12; t++) begin
            mc = N'($urandom_range(0, 7));
            mp = N'($urandom_range(0, 7));
            do_run(mc, mp, 0);
            n_checks++;
            if (done_cyc !== 2 * N + ref_k(mp) + 3) begin
                n_fail++; $display("FAIL rnd_done_cycle mc=%0d mp=%0d: got %0d expected %0d",
                    mc, mp, done_cyc, 2 * N + ref_k(mp) + 3);
            end
            n_checks++;
            if (prod !== ref_prod(mc, mp)) begin
                n_fail++; $display("FAIL rnd_product mc=%0d mp=%0d: got %b expected %b", mc, mp, prod, ref_prod(mc, mp));
            end
            n_checks++;
            if (seq_code !== ref_seq(mp)) begin
                n_fail++; $display("FAIL rnd_strobes mp=%0d: got %o expected %o", mp, seq_code, ref_seq(mp));
            end
            n_checks++;
            if (err_done !== 1'b0 || multi != 0 || gaps != 0) begin
                n_fail++; $display("FAIL rnd_err_onehot: got err=%b multi=%0d gaps=%0d expected 0 0 0", err_done, multi, gaps);
            end
        end
    endtask

    task automatic test_reset_mid;
        int shifts = 0;
        int bad = 0;
        mcnd_in = 3'd2; mplr_in = 3'd3;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int c = 0; c < 30 && shifts < 2; c++) begin
            @(negedge clk);
            if (bus.shft) shifts++;
        end
        n_checks++;
        if (shifts != 2) begin
            n_fail++; $display("FAIL rstmid_second_shift: got %0d shifts expected 2", shifts);
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.clr, bus.ld, bus.add_sub, bus.shft, bus.busy, bus.done, bus.err} !== 7'b0) begin
            n_fail++; $display("FAIL rstmid_async_clear: got %b expected 0000000",
                {bus.clr, bus.ld, bus.add_sub, bus.shft, bus.busy, bus.done, bus.err});
        end
        #1 rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.done || bus.busy) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL rstmid_no_done: got %0d busy/done cycles expected 0", bad);
        end
        do_run(3'd2, 3'd3, 0);
        n_checks++;
        if (done_cyc !== 11 || prod !== 6'd6 || seq_code !== 32'o1234434) begin
            n_fail++; $display("FAIL rstmid_next_run: got cyc=%0d p=%0d seq=%o expected 11 6 1234434", done_cyc, prod, seq_code);
        end
    endtask

    task automatic test_err;
        int lost = 0;
        force0 = 1'b1;
        do_run(3'd2, 3'd3, 0);
        force0 = 1'b0;
        n_checks++;
        if (done_cyc !== 4 || err_done !== 1'b1 || seq_code !== 32'o12) begin
            n_fail++; $display("FAIL err_premature: got cyc=%0d err=%b seq=%o expected 4 1 12", done_cyc, err_done, seq_code);
        end
        n_checks++;
        if (post_err !== 1'b1 || post_busy !== 1'b0) begin
            n_fail++; $display("FAIL err_idle_hold: got err=%b busy=%b expected 1 0", post_err, post_busy);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus.err !== 1'b1) lost++;
        end
        n_checks++;
        if (lost != 0) begin
            n_fail++; $display("FAIL err_sticky: got %0d cycles with err low expected 0", lost);
        end
        do_run(3'd2, 3'd3, 0);
        n_checks++;
        if (err_c1 !== 1'b0 || err_done !== 1'b0 || done_cyc !== 11) begin
            n_fail++; $display("FAIL err_cleared: got clear_err=%b fin_err=%b cyc=%0d expected 0 0 11", err_c1, err_done, done_cyc);
        end
        force1 = 1'b1;
        do_run(3'd1, 3'd0, 0);
        force1 = 1'b0;
        n_checks++;
        if (done_cyc !== 9 || err_done !== 1'b0 || post_err !== 1'b1) begin
            n_fail++; $display("FAIL err_fin_incr: got cyc=%0d fin_err=%b idle_err=%b expected 9 0 1", done_cyc, err_done, post_err);
        end
    endtask

    task automatic test_back_to_back;
        logic [N-1:0] mc, mp;
        int extra = 0;
        do_run(3'd3, 3'b101, 2);
        n_checks++;
        if (done_cyc !== 12 || prod !== 6'b110111 || post_busy !== 1'b0 || post_done !== 1'b0) begin
            n_fail++; $display("FAIL b2b_first: got cyc=%0d p=%b busy=%b done=%b expected 12 110111 0 0",
                done_cyc, prod, post_busy, post_done);
        end
        mc = N'($urandom_range(0, 7));
        mp = N'($urandom_range(0, 7));
        do_run(mc, mp, 1);
        n_checks++;
        if (done_cyc !== 2 * N + ref_k(mp) + 3 || prod !== ref_prod(mc, mp) || gaps != 0) begin
            n_fail++; $display("FAIL b2b_second: got cyc=%0d p=%b gaps=%0d expected %0d %b 0",
                done_cyc, prod, gaps, 2 * N + ref_k(mp) + 3, ref_prod(mc, mp));
        end
        do_run(3'd2, 3'd3, 0);
        n_checks++;
        if (done_cyc !== 11 || prod !== 6'd6) begin
            n_fail++; $display("FAIL b2b_third: got cyc=%0d p=%0d expected 11 6", done_cyc, prod);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.busy) extra++;
        end
        n_checks++;
        if (extra != 0) begin
            n_fail++; $display("FAIL b2b_not_queued: got %0d busy cycles expected 0", extra);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        mcnd_in = '0;
        mplr_in = '0;
        test_reset();
        test_directed();
        test_random();
        test_reset_mid();
        test_err();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
